// File: rtl/csa_reduce_pipe_pkg.sv
// Shared sizing helpers for the carry-save reduction pipeline.
// No logic: constant functions only, evaluated at elaboration.
// No flow control: consumers derive their widths and stage counts from these.
package csa_pkg;

    // Ceiling log2 for elaboration-time sizing (value >= 1)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Each 4:2 level halves the operand count until a single (sum, carry) pair remains
    function automatic int csa_levels(input int num_ops);
        return clog2(num_ops) - 1;
    endfunction

    // Enough headroom that the unsigned total of all operands never wraps
    function automatic int csa_out_w(input int width, input int num_ops);
        return width + clog2(num_ops);
    endfunction

endpackage

// File: rtl/csa_reduce_pipe_compressor_42_row.sv
// One row of W proper 4:2 compressor cells reducing a+b+c+d to sum + carry (modulo 2^W).
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline stage decides when results are captured.
module compressor_42_row #(
    parameter int W = 19
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] s1;
    logic [W-1:0] cin;

    // First full adder per cell feeds its majority (cout) into the next cell's cin; cout of the
    // MSB cell is dropped. The second full adder's carry is emitted already shifted to weight 2.
    always_comb begin
        s1    = a ^ b ^ c;
        cin   = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};
        sum   = s1 ^ d ^ cin;
        carry = {(s1[W-2:0] & d[W-2:0]) | (s1[W-2:0] & cin[W-2:0]) | (d[W-2:0] & cin[W-2:0]), 1'b0};
    end

endmodule

// File: rtl/csa_reduce_pipe.sv
// Pipelined 4:2 carry-save tree: NUM_OPS operands -> one redundant (sum, carry) pair plus tag.
// Latency: LEVELS cycles with no stall, one register stage per compressor level.
// Backpressure: valid/ready per stage, ready ripples back combinationally so bubbles collapse.
module csa_reduce_pipe
    import csa_pkg::*;
#(
    parameter int  WIDTH   = 16,
    parameter int  NUM_OPS = 8,
    parameter int  SIGNED  = 0,
    parameter int  TAG_W   = 4,
    localparam int OUT_W   = csa_out_w(WIDTH, NUM_OPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] ops_i,
    input  logic [TAG_W-1:0]         tag_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         sum_o,
    output logic [OUT_W-1:0]         carry_o,
    output logic [TAG_W-1:0]         tag_o
);

    localparam int LEVELS = csa_levels(NUM_OPS);

    // Stage i here is compressor level i+1; stage LEVELS-1 drives the outputs
    logic [LEVELS-1:0] valid_q;
    logic [LEVELS-1:0] valid_d;
    logic [LEVELS-1:0] load;
    logic [LEVELS-1:0] ld_en;

    // Ready ripples back from the output: a stage may load when empty or when its occupant leaves
    always_comb begin
        logic nxt;
        nxt  = out_ready;
        load = '0;
        for (int i = LEVELS - 1; i >= 0; i--) begin
            load[i] = !valid_q[i] || nxt;
            nxt     = load[i];
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[LEVELS-1];

    // Each loading stage takes the valid of its upstream neighbour; data only moves for real items
    always_comb begin
        logic src;
        src     = in_valid;
        valid_d = valid_q;
        ld_en   = '0;
        for (int i = 0; i < LEVELS; i++) begin
            if (load[i]) begin
                valid_d[i] = src;
            end
            ld_en[i] = load[i] && src;
            src      = valid_q[i];
        end
    end

    // Valid bits always reset so in-flight items are dropped on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    genvar lv, r;
    for (lv = 0; lv <= LEVELS; lv++) begin : g_lvl
        localparam int N_NODE = NUM_OPS >> lv;
        logic [OUT_W-1:0] node [N_NODE];
        logic [TAG_W-1:0] node_tag;

        if (lv == 0) begin : g_ext
            // Widen each operand to the output width so no level can overflow before the modulo wrap
            always_comb begin
                for (int k = 0; k < NUM_OPS; k++) begin
                    if (SIGNED != 0) begin
                        node[k] = OUT_W'($signed(ops_i[k*WIDTH +: WIDTH]));
                    end else begin
                        node[k] = OUT_W'(ops_i[k*WIDTH +: WIDTH]);
                    end
                end
            end
            assign node_tag = tag_i;
        end else begin : g_stage
            localparam int N_ROWS = N_NODE / 2;
            logic [OUT_W-1:0] row_sum   [N_ROWS];
            logic [OUT_W-1:0] row_carry [N_ROWS];
            logic [OUT_W-1:0] data_d    [N_NODE];
            logic [OUT_W-1:0] data_q    [N_NODE];
            logic [TAG_W-1:0] tag_d;
            logic [TAG_W-1:0] tag_q;

            for (r = 0; r < N_ROWS; r++) begin : g_row
                compressor_42_row #(.W(OUT_W)) u_row (
                    .a     (g_lvl[lv-1].node[4*r]),
                    .b     (g_lvl[lv-1].node[4*r+1]),
                    .c     (g_lvl[lv-1].node[4*r+2]),
                    .d     (g_lvl[lv-1].node[4*r+3]),
                    .sum   (row_sum[r]),
                    .carry (row_carry[r])
                );
            end

            // Capture fresh row results when an item enters this stage, otherwise hold
            always_comb begin
                tag_d = tag_q;
                for (int k = 0; k < N_NODE; k++) begin
                    data_d[k] = data_q[k];
                end
                if (ld_en[lv-1]) begin
                    tag_d = g_lvl[lv-1].node_tag;
                    for (int k = 0; k < N_ROWS; k++) begin
                        data_d[2*k]   = row_sum[k];
                        data_d[2*k+1] = row_carry[k];
                    end
                end
            end

            if (lv == LEVELS) begin : g_out_reg
                // Output stage clears so the visible result is zero during and after reset
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        tag_q <= '0;
                        for (int k = 0; k < N_NODE; k++) begin
                            data_q[k] <= '0;
                        end
                    end else begin
                        tag_q  <= tag_d;
                        data_q <= data_d;
                    end
                end
            end else begin : g_mid_reg
                // Inner stages are qualified by their valid bit, so their data needs no reset
                always_ff @(posedge clk) begin
                    tag_q  <= tag_d;
                    data_q <= data_d;
                end
            end

            assign node     = data_q;
            assign node_tag = tag_q;
        end
    end

    assign sum_o   = g_lvl[LEVELS].node[0];
    assign carry_o = g_lvl[LEVELS].node[1];
    assign tag_o   = g_lvl[LEVELS].node_tag;

endmodule

// File: tb/tb_csa_reduce_pipe.sv
module tb_csa_reduce_pipe;

    localparam int WIDTH   = 16;
    localparam int NUM_OPS = 8;
    localparam int TAG_W   = 4;
    localparam int OUT_W   = 19;
    localparam int OPS_W   = WIDTH * NUM_OPS;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             out_ready;
    logic [OPS_W-1:0] ops_i;
    logic [TAG_W-1:0] tag_i;

    logic             in_ready_u, out_valid_u;
    logic [OUT_W-1:0] sum_u, carry_u;
    logic [TAG_W-1:0] tag_u;
    logic             in_ready_s, out_valid_s;
    logic [OUT_W-1:0] sum_s, carry_s;
    logic [TAG_W-1:0] tag_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csa_reduce_pipe #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .SIGNED(0), .TAG_W(TAG_W)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .ops_i(ops_i),
        .tag_i(tag_i), .out_valid(out_valid_u), .out_ready(out_ready), .sum_o(sum_u),
        .carry_o(carry_u), .tag_o(tag_u)
    );

    csa_reduce_pipe #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .SIGNED(1), .TAG_W(TAG_W)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .ops_i(ops_i),
        .tag_i(tag_i), .out_valid(out_valid_s), .out_ready(out_ready), .sum_o(sum_s),
        .carry_o(carry_s), .tag_o(tag_s)
    );

    // Reference: plain integer sum of the extended operands, reduced modulo 2^OUT_W
    function automatic logic [OUT_W-1:0] model_total(input logic [OPS_W-1:0] ops, input bit sgn);
        longint acc;
        logic [WIDTH-1:0] o;
        acc = 0;
        for (int k = 0; k < NUM_OPS; k++) begin
            o = ops[k*WIDTH +: WIDTH];
            if (sgn) acc += longint'($signed(o));
            else     acc += longint'(o);
        end
        return acc[OUT_W-1:0];
    endfunction

    function automatic logic [OPS_W-1:0] rand_ops();
        logic [OPS_W-1:0] v;
        for (int k = 0; k < OPS_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one item with out_ready high and return what emerges plus the observed latency
    task automatic send_and_get(input logic [OPS_W-1:0] ops, input logic [TAG_W-1:0] tag,
                                output logic [OUT_W-1:0] tot_u, output logic [OUT_W-1:0] tot_s,
                                output logic [TAG_W-1:0] tg_u, output logic [TAG_W-1:0] tg_s,
                                output int lat, output logic c0);
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        ops_i     = ops;
        tag_i     = tag;
        #1;
        n = 0;
        while (!in_ready_u && n < 20) begin
            step();
            n++;
        end
        step();
        in_valid = 1'b0;
        ops_i    = rand_ops();
        lat      = 1;
        #1;
        while (!(out_valid_u && out_valid_s) && lat < 20) begin
            step();
            lat++;
        end
        tot_u = sum_u + carry_u;
        tot_s = sum_s + carry_s;
        tg_u  = tag_u;
        tg_s  = tag_s;
        c0    = carry_u[0] | carry_s[0];
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ops_i = '0; tag_i = '0;
        #3;
        checks++;
        if ({out_valid_u, out_valid_s} !== 2'b00) begin
            failures++; $display("FAIL reset_out_valid got=%b want=00", {out_valid_u, out_valid_s});
        end
        checks++;
        if ({sum_u, carry_u, tag_u, sum_s, carry_s, tag_s} !== '0) begin
            failures++; $display("FAIL reset_outputs got sum=%h carry=%h tag=%h want 0", sum_u, carry_u, tag_u);
        end
        step(); step();
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready_u, in_ready_s} !== 2'b11) begin
            failures++; $display("FAIL reset_in_ready got=%b want=11", {in_ready_u, in_ready_s});
        end
    endtask

    task automatic test_basic();
        logic [OPS_W-1:0] ops;
        logic [OUT_W-1:0] tu, ts;
        logic [TAG_W-1:0] gu, gs;
        int lat;
        logic c0;
        for (int k = 0; k < NUM_OPS; k++) ops[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
        send_and_get(ops, 4'h3, tu, ts, gu, gs, lat, c0);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL basic_latency got=%0d want=2", lat); end
        checks++;
        if (tu !== 19'h00024 || ts !== 19'h00024) begin
            failures++; $display("FAIL basic_total got u=%h s=%h want=00024", tu, ts);
        end
        checks++;
        if (gu !== 4'h3 || gs !== 4'h3) begin failures++; $display("FAIL basic_tag got u=%h s=%h want=3", gu, gs); end
        checks++;
        if (c0 !== 1'b0) begin failures++; $display("FAIL basic_carry_bit0 got=%b want=0", c0); end
    endtask

    task automatic test_extremes();
        logic [WIDTH-1:0] lo [4] = '{16'hFFFF, 16'h8000, 16'hFFFF, 16'h0003};
        logic [WIDTH-1:0] hi [4] = '{16'hFFFF, 16'h8000, 16'h0001, 16'h0003};
        logic [OUT_W-1:0] exp_u [4] = '{19'h7FFF8, 19'h40000, 19'h40000, 19'h00018};
        logic [OUT_W-1:0] exp_s [4] = '{19'h7FFF8, 19'h40000, 19'h00000, 19'h00018};
        logic [OPS_W-1:0] ops;
        logic [OUT_W-1:0] tu, ts;
        logic [TAG_W-1:0] gu, gs, tg;
        int lat;
        logic c0;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < NUM_OPS; k++) ops[k*WIDTH +: WIDTH] = (k < 4) ? lo[p] : hi[p];
            tg = TAG_W'($urandom);
            send_and_get(ops, tg, tu, ts, gu, gs, lat, c0);
            checks++;
            if (tu !== exp_u[p]) begin failures++; $display("FAIL extreme%0d_unsigned got=%h want=%h", p, tu, exp_u[p]); end
            checks++;
            if (ts !== exp_s[p]) begin failures++; $display("FAIL extreme%0d_signed got=%h want=%h", p, ts, exp_s[p]); end
            checks++;
            if (gu !== tg || gs !== tg || lat !== 2) begin
                failures++; $display("FAIL extreme%0d_tag_lat got tag=%h/%h lat=%0d want tag=%h lat=2", p, gu, gs, lat, tg);
            end
        end
    endtask

    task automatic test_full();
        logic [OPS_W-1:0] it [4];
        logic [3:0] rdy_log;
        logic [OUT_W-1:0] tu, ts;
        int idx, outn, gaps, cyc;
        logic acc;
        for (int i = 0; i < 4; i++) it[i] = rand_ops();
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; ops_i = it[idx]; tag_i = TAG_W'(idx + 5);
            #1;
            rdy_log[c] = in_ready_u & in_ready_s;
            if (in_ready_u) idx++;
            step();
        end
        checks++;
        if (idx !== 2 || rdy_log !== 4'b0011) begin
            failures++; $display("FAIL full_accept got accepted=%0d ready=%b want accepted=2 ready=0011", idx, rdy_log);
        end
        out_ready = 1'b1;
        outn = 0; gaps = 0; cyc = 0;
        while (outn < 4 && cyc < 20) begin
            in_valid = (idx < 4);
            ops_i    = (idx < 4) ? it[idx] : rand_ops();
            tag_i    = TAG_W'(idx + 5);
            #1;
            acc = in_valid && in_ready_u;
            if (out_valid_u) begin
                tu = sum_u + carry_u;
                ts = sum_s + carry_s;
                checks++;
                if (tu !== model_total(it[outn], 0) || ts !== model_total(it[outn], 1) ||
                    tag_u !== TAG_W'(outn + 5) || tag_s !== TAG_W'(outn + 5)) begin
                    failures++;
                    $display("FAIL full_item%0d got u=%h s=%h tag=%h want u=%h s=%h tag=%h", outn, tu, ts, tag_u,
                             model_total(it[outn], 0), model_total(it[outn], 1), TAG_W'(outn + 5));
                end
                outn++;
            end else if (outn > 0) begin
                gaps++;
            end
            if (acc) idx++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (outn !== 4 || idx !== 4 || gaps !== 0) begin
            failures++; $display("FAIL full_drain got out=%0d in=%0d gaps=%0d want 4 4 0", outn, idx, gaps);
        end
    endtask

    task automatic test_back_to_back();
        logic [OUT_W-1:0] q_u [$];
        logic [OUT_W-1:0] q_s [$];
        logic [TAG_W-1:0] q_t [$];
        logic [OUT_W-1:0] eu, es, hold_sum, hold_carry;
        logic [TAG_W-1:0] et, hold_tag;
        logic prev_stall;
        int sent, recv, cyc, bad, stall_bad;
        sent = 0; recv = 0; cyc = 0; bad = 0; stall_bad = 0; prev_stall = 1'b0;
        hold_sum = '0; hold_carry = '0; hold_tag = '0;
        while (recv < 1000 && cyc < 20000) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
            ops_i     = rand_ops();
            tag_i     = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (prev_stall) begin
                checks++;
                if (!out_valid_u || sum_u !== hold_sum || carry_u !== hold_carry || tag_u !== hold_tag) begin
                    failures++; stall_bad++;
                    if (stall_bad < 5) $display("FAIL b2b_stall_hold cycle=%0d got vld=%b sum=%h want sum=%h", cyc, out_valid_u, sum_u, hold_sum);
                end
            end
            if (in_valid && in_ready_u) begin
                q_u.push_back(model_total(ops_i, 0));
                q_s.push_back(model_total(ops_i, 1));
                q_t.push_back(tag_i);
                sent++;
            end
            if (out_valid_u && out_ready) begin
                checks++;
                if (q_u.size() == 0) begin
                    failures++; bad++;
                    $display("FAIL b2b_spurious cycle=%0d got an output want none", cyc);
                end else begin
                    eu = q_u.pop_front(); es = q_s.pop_front(); et = q_t.pop_front();
                    if (19'(sum_u + carry_u) !== eu || 19'(sum_s + carry_s) !== es ||
                        tag_u !== et || tag_s !== et || out_valid_s !== 1'b1) begin
                        failures++; bad++;
                        if (bad < 5) $display("FAIL b2b_item%0d got u=%h s=%h tag=%h want u=%h s=%h tag=%h", recv,
                                              19'(sum_u + carry_u), 19'(sum_s + carry_s), tag_u, eu, es, et);
                    end
                end
                recv++;
            end
            prev_stall = out_valid_u && !out_ready;
            hold_sum = sum_u; hold_carry = carry_u; hold_tag = tag_u;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (recv !== 1000 || q_u.size() !== 0) begin
            failures++; $display("FAIL b2b_count got recv=%0d pending=%0d want 1000 0", recv, q_u.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic [OPS_W-1:0] ops;
        logic [OUT_W-1:0] tu, ts;
        logic [TAG_W-1:0] gu, gs, tg;
        int lat;
        logic c0;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; ops_i = rand_ops() | 128'h1; tag_i = TAG_W'(i + 9);
            step();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid_u !== 1'b1) begin failures++; $display("FAIL midrst_prefill got vld=%b want=1", out_valid_u); end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid_u, out_valid_s} !== 2'b00 || {sum_u, carry_u, tag_u, sum_s, carry_s, tag_s} !== '0) begin
            failures++; $display("FAIL midrst_clear got vld=%b sum=%h carry=%h tag=%h want all 0", out_valid_u, sum_u, carry_u, tag_u);
        end
        step(); step();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready_u !== 1'b1 || out_valid_u !== 1'b0) begin
            failures++; $display("FAIL midrst_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready_u, out_valid_u);
        end
        ops = rand_ops();
        tg  = TAG_W'($urandom);
        send_and_get(ops, tg, tu, ts, gu, gs, lat, c0);
        checks++;
        if (tu !== model_total(ops, 0) || ts !== model_total(ops, 1) || gu !== tg || lat !== 2) begin
            failures++; $display("FAIL midrst_next got u=%h s=%h tag=%h lat=%0d want u=%h s=%h tag=%h lat=2",
                                 tu, ts, gu, lat, model_total(ops, 0), model_total(ops, 1), tg);
        end
        #1;
        checks++;
        if (out_valid_u !== 1'b0) begin failures++; $display("FAIL midrst_stale got vld=%b want=0", out_valid_u); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_full();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
